// File: rtl/alu_ctrl_fsm.sv
// RV32I multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB driving ALU op, operand muxes and strobes.
// Optional ALU_CTRL_ILLEGAL_TRAP_EN: illegal encodings lock into TRAP with the illegal output held high.
module alu_ctrl_fsm #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        alu_zero,
  input  logic        alu_lt,
  output logic [3:0]  aluop,
  output logic        alumux1_sel,
  output logic        alumux2_sel,
  output logic [2:0]  imm_sel,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [1:0]  pc_sel,
  output logic        pc_we,
  output logic        mem_timeout
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] AOP_ADD   = 4'b0000;
  localparam logic [3:0] AOP_SUB   = 4'b0001;
  localparam logic [3:0] AOP_SLT   = 4'b0011;
  localparam logic [3:0] AOP_SLTU  = 4'b0100;
  localparam logic [3:0] AOP_PASSB = 4'b1111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    ,
    TRAP
`endif
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LUI, C_AUIPC, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_ILL
  } cls_t;

  state_t     state, next;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic       f7_q;
  cls_t       cls_q, cls_d;
  logic [3:0] aluop_q, aluop_d;
  logic       mux1_q, mux1_d, mux2_q, mux2_d;
  logic [2:0] imm_q, imm_d;
  logic [7:0] wcnt, wcnt_d;

  logic       ireq_c, dreq_c, dwe_c, irwe_c, regwe_c, pcwe_c, mto_c, m1_c, m2_c;
  logic [3:0] aluop_c;
  logic [2:0] imm_c;
  logic [1:0] wbsel_c, pcsel_c;
  logic       br_taken;

  logic unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_fn = alt ? 4'b0001 : 4'b0000;
      3'b001:  alu_fn = 4'b0010;
      3'b010:  alu_fn = 4'b0011;
      3'b011:  alu_fn = 4'b0100;
      3'b100:  alu_fn = 4'b0101;
      3'b101:  alu_fn = alt ? 4'b0111 : 4'b0110;
      3'b110:  alu_fn = 4'b1000;
      default: alu_fn = 4'b1001;
    endcase
  endfunction

  // Decode of the fields captured at the fetch ack; results are registered on leaving DECODE.
  always_comb begin
    cls_d   = C_ILL;
    aluop_d = AOP_ADD;
    mux1_d  = 1'b0;
    mux2_d  = 1'b0;
    imm_d   = IMM_I;
    case (op_q)
      OP_R: begin
        cls_d   = C_R;
        aluop_d = alu_fn(f3_q, f7_q);
      end
      OP_I: begin
        cls_d   = C_I;
        aluop_d = alu_fn(f3_q, f7_q & (f3_q == 3'b101));
        mux2_d  = 1'b1;
      end
      OP_LUI: begin
        cls_d   = C_LUI;
        aluop_d = AOP_PASSB;
        mux2_d  = 1'b1;
        imm_d   = IMM_U;
      end
      OP_AUIPC: begin
        cls_d  = C_AUIPC;
        mux1_d = 1'b1;
        mux2_d = 1'b1;
        imm_d  = IMM_U;
      end
      OP_LOAD: begin
        if (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          cls_d  = C_LOAD;
          mux2_d = 1'b1;
        end
      end
      OP_STORE: begin
        if (f3_q inside {3'b000, 3'b001, 3'b010}) begin
          cls_d  = C_STORE;
          mux2_d = 1'b1;
          imm_d  = IMM_S;
        end
      end
      OP_BRANCH: begin
        if (f3_q[2:1] != 2'b01) begin
          cls_d   = C_BR;
          aluop_d = f3_q[2] ? (f3_q[1] ? AOP_SLTU : AOP_SLT) : AOP_SUB;
          imm_d   = IMM_B;
        end
      end
      OP_JAL: begin
        cls_d = C_JAL;
        imm_d = IMM_J;
      end
      OP_JALR: begin
        cls_d  = C_JALR;
        mux2_d = 1'b1;
      end
      default: ;
    endcase
  end

  // beq/bne test the zero flag, the rest the lt flag; funct3[0] inverts the sense.
  assign br_taken = f3_q[2] ? (alu_lt ^ f3_q[0]) : (alu_zero ^ f3_q[0]);

  always_comb begin
    next    = state;
    wcnt_d  = '0;
    ireq_c  = 1'b0;
    dreq_c  = 1'b0;
    dwe_c   = 1'b0;
    irwe_c  = 1'b0;
    regwe_c = 1'b0;
    pcwe_c  = 1'b0;
    mto_c   = 1'b0;
    aluop_c = '0;
    m1_c    = 1'b0;
    m2_c    = 1'b0;
    wbsel_c = 2'd0;
    pcsel_c = 2'd0;
    imm_c   = (state == DECODE) ? imm_d : imm_q;
    case (state)
      FETCH: begin
        if (imem_ack) begin
          irwe_c = 1'b1;
          next   = DECODE;
        end else if (wcnt == WAIT_LIMIT) begin
          mto_c = 1'b1;
        end else begin
          ireq_c = 1'b1;
          wcnt_d = wcnt + 8'd1;
        end
      end
      DECODE: begin
        next = EXEC;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        if (cls_d == C_ILL) next = TRAP;
`endif
      end
      EXEC: begin
        aluop_c = aluop_q;
        m1_c    = mux1_q;
        m2_c    = mux2_q;
        case (cls_q)
          C_LOAD, C_STORE: next = MEM;
          C_BR: begin
            pcwe_c  = 1'b1;
            pcsel_c = {1'b0, br_taken};
            next    = FETCH;
          end
          C_ILL: begin
            pcwe_c = 1'b1;
            next   = FETCH;
          end
          default: next = WB;
        endcase
      end
      MEM: begin
        aluop_c = aluop_q;
        m1_c    = mux1_q;
        m2_c    = mux2_q;
        if (dmem_ack) begin
          if (cls_q == C_STORE) begin
            pcwe_c = 1'b1;
            next   = FETCH;
          end else begin
            next = WB;
          end
        end else if (wcnt == WAIT_LIMIT) begin
          mto_c = 1'b1;
          next  = FETCH;
        end else begin
          dreq_c = 1'b1;
          dwe_c  = (cls_q == C_STORE);
          wcnt_d = wcnt + 8'd1;
        end
      end
      WB: begin
        regwe_c = 1'b1;
        pcwe_c  = 1'b1;
        next    = FETCH;
        case (cls_q)
          C_LOAD: wbsel_c = 2'd1;
          C_JAL: begin
            wbsel_c = 2'd2;
            pcsel_c = 2'd1;
          end
          C_JALR: begin
            wbsel_c = 2'd2;
            pcsel_c = 2'd2;
          end
          default: ;
        endcase
      end
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      TRAP: next = TRAP;
`endif
      default: next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      wcnt    <= '0;
      op_q    <= '0;
      f3_q    <= '0;
      f7_q    <= 1'b0;
      cls_q   <= C_ILL;
      aluop_q <= '0;
      mux1_q  <= 1'b0;
      mux2_q  <= 1'b0;
      imm_q   <= '0;
    end else begin
      state <= next;
      wcnt  <= wcnt_d;
      if (state == FETCH && imem_ack) begin
        op_q <= instr[6:0];
        f3_q <= instr[14:12];
        f7_q <= instr[30];
      end
      if (state == DECODE) begin
        cls_q   <= cls_d;
        aluop_q <= aluop_d;
        mux1_q  <= mux1_d;
        mux2_q  <= mux2_d;
        imm_q   <= imm_d;
      end
    end
  end

  // Outputs are Mealy on the acks; forcing them low under reset keeps imem_req quiet while held in FETCH.
  assign {imem_req, dmem_req, dmem_we, aluop, alumux1_sel, alumux2_sel, imm_sel,
          ir_we, reg_we, wb_sel, pc_sel, pc_we, mem_timeout} =
         rst_n ? {ireq_c, dreq_c, dwe_c, aluop_c, m1_c, m2_c, imm_c,
                  irwe_c, regwe_c, wbsel_c, pcsel_c, pcwe_c, mto_c} : '0;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign illegal = rst_n && (state == TRAP);
`endif

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm (TIMEOUT=4); every output is compared as one packed vector per cycle.
// Build with ALU_CTRL_ILLEGAL_TRAP_EN to exercise the trap path instead of the illegal-NOP path.
module tb_alu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, alu_zero, alu_lt;
  logic [3:0]  aluop;
  logic        alumux1_sel, alumux2_sel, ir_we, reg_we, pc_we, mem_timeout;
  logic [2:0]  imm_sel;
  logic [1:0]  wb_sel, pc_sel;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [2:0]  cur_isel = 3'd0;
  logic [19:0] obs;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRA  = 32'h4020D1B3;
  localparam logic [31:0] I_SRAI = 32'h4030D193;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_AUI  = 32'h00000197;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_JALR = 32'h000080E7;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_BNE  = 32'h00209063;
  localparam logic [31:0] I_BLT  = 32'h0020C063;
  localparam logic [31:0] I_BGEU = 32'h0020F063;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0030A023;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  always #5 clk = ~clk;

  alu_ctrl_fsm #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_zero(alu_zero), .alu_lt(alu_lt),
    .aluop(aluop), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
    .imm_sel(imm_sel), .ir_we(ir_we), .reg_we(reg_we), .wb_sel(wb_sel),
    .pc_sel(pc_sel), .pc_we(pc_we), .mem_timeout(mem_timeout)
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  assign obs = {imem_req, dmem_req, dmem_we, aluop, alumux1_sel, alumux2_sel, imm_sel,
                ir_we, reg_we, wb_sel, pc_sel, pc_we, mem_timeout};

  function automatic logic [19:0] pk(input logic ireq, input logic dreq, input logic dwe,
                                     input logic [3:0] aop, input logic m1, input logic m2,
                                     input logic [2:0] isel, input logic irwe, input logic rwe,
                                     input logic [1:0] wbs, input logic [1:0] pcs,
                                     input logic pcwe, input logic mto);
    return {ireq, dreq, dwe, aop, m1, m2, isel, irwe, rwe, wbs, pcs, pcwe, mto};
  endfunction

  task automatic chk(input string tag, input logic [19:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic o, input logic exp);
    vectors++;
    assert (o === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, o, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag);
    imem_ack = 1'b0;
    #1;
    chk(tag, pk(1, 0, 0, 4'h0, 0, 0, cur_isel, 0, 0, 2'd0, 2'd0, 0, 0));
  endtask

  task automatic fetch(input string tag, input logic [31:0] w, input int unsigned waits);
    for (int unsigned i = 0; i < waits; i++) begin
      chk_fetch({tag, "/wait"});
      tick();
    end
    instr = w;
    imem_ack = 1'b1;
    #1;
    chk({tag, "/ack"}, pk(0, 0, 0, 4'h0, 0, 0, cur_isel, 1, 0, 2'd0, 2'd0, 0, 0));
    tick();
    imem_ack = 1'b0;
    instr = '1;
  endtask

  task automatic decode(input string tag, input logic [2:0] isel);
    #1;
    chk({tag, "/dec"}, pk(0, 0, 0, 4'h0, 0, 0, isel, 0, 0, 2'd0, 2'd0, 0, 0));
    cur_isel = isel;
    tick();
  endtask

  task automatic do_wb(input string tag, input logic [31:0] w, input int unsigned waits,
                       input logic [3:0] aop, input logic m1, input logic m2,
                       input logic [2:0] isel, input logic [1:0] wbs, input logic [1:0] pcs);
    fetch(tag, w, waits);
    decode(tag, isel);
    #1;
    chk({tag, "/exec"}, pk(0, 0, 0, aop, m1, m2, isel, 0, 0, 2'd0, 2'd0, 0, 0));
    tick();
    #1;
    chk({tag, "/wb"}, pk(0, 0, 0, 4'h0, 0, 0, isel, 0, 1, wbs, pcs, 1, 0));
    tick();
    chk_fetch({tag, "/next"});
  endtask

  task automatic do_br(input string tag, input logic [31:0] w, input logic z, input logic lt,
                       input logic [3:0] aop, input logic taken);
    fetch(tag, w, 0);
    decode(tag, 3'd2);
    alu_zero = z;
    alu_lt = lt;
    #1;
    chk({tag, "/exec"}, pk(0, 0, 0, aop, 0, 0, 3'd2, 0, 0, 2'd0, {1'b0, taken}, 1, 0));
    tick();
    alu_zero = 1'b0;
    alu_lt = 1'b0;
    chk_fetch({tag, "/next"});
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    instr = '0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    alu_zero = 1'b0;
    alu_lt = 1'b0;
    #1;
    chk("reset_t0", '0);
    tick();
    tick();
    chk("reset_held", '0);
    rst_n = 1'b1;

    // ALU class, first instruction with two fetch wait cycles
    do_wb("add",   I_ADD,  2, 4'b0000, 0, 0, 3'd0, 2'd0, 2'd0);
    do_wb("sub",   I_SUB,  0, 4'b0001, 0, 0, 3'd0, 2'd0, 2'd0);
    do_wb("sra",   I_SRA,  1, 4'b0111, 0, 0, 3'd0, 2'd0, 2'd0);
    do_wb("srai",  I_SRAI, 0, 4'b0111, 0, 1, 3'd0, 2'd0, 2'd0);
    do_wb("lui",   I_LUI,  0, 4'b1111, 0, 1, 3'd3, 2'd0, 2'd0);
    do_wb("auipc", I_AUI,  0, 4'b0000, 1, 1, 3'd3, 2'd0, 2'd0);
    do_wb("jal",   I_JAL,  0, 4'b0000, 0, 0, 3'd4, 2'd2, 2'd1);
    do_wb("jalr",  I_JALR, 0, 4'b0000, 0, 1, 3'd0, 2'd2, 2'd2);

    do_br("beq_t",  I_BEQ,  1, 0, 4'b0001, 1);
    do_br("beq_nt", I_BEQ,  0, 0, 4'b0001, 0);
    do_br("bne_nt", I_BNE,  1, 0, 4'b0001, 0);
    do_br("blt_t",  I_BLT,  0, 1, 4'b0011, 1);
    do_br("bgeu_t", I_BGEU, 0, 0, 4'b0100, 1);

    // Load with three data wait cycles
    fetch("lw", I_LW, 0);
    decode("lw", 3'd0);
    #1;
    chk("lw/exec", pk(0, 0, 0, 4'h0, 0, 1, 3'd0, 0, 0, 2'd0, 2'd0, 0, 0));
    tick();
    for (int i = 0; i < 3; i++) begin
      dmem_ack = 1'b0;
      #1;
      chk("lw/mem_wait", pk(0, 1, 0, 4'h0, 0, 1, 3'd0, 0, 0, 2'd0, 2'd0, 0, 0));
      tick();
    end
    dmem_ack = 1'b1;
    #1;
    chk("lw/mem_ack", pk(0, 0, 0, 4'h0, 0, 1, 3'd0, 0, 0, 2'd0, 2'd0, 0, 0));
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("lw/wb", pk(0, 0, 0, 4'h0, 0, 0, 3'd0, 0, 1, 2'd1, 2'd0, 1, 0));
    tick();
    chk_fetch("lw/next");

    // Store with one data wait cycle
    fetch("sw", I_SW, 0);
    decode("sw", 3'd1);
    #1;
    chk("sw/exec", pk(0, 0, 0, 4'h0, 0, 1, 3'd1, 0, 0, 2'd0, 2'd0, 0, 0));
    tick();
    #1;
    chk("sw/mem_wait", pk(0, 1, 1, 4'h0, 0, 1, 3'd1, 0, 0, 2'd0, 2'd0, 0, 0));
    tick();
    dmem_ack = 1'b1;
    #1;
    chk("sw/mem_ack", pk(0, 0, 0, 4'h0, 0, 1, 3'd1, 0, 0, 2'd0, 2'd0, 1, 0));
    tick();
    dmem_ack = 1'b0;
    chk_fetch("sw/next");

    // Fetch timeout: four request cycles, then an abort cycle, then refetch
    for (int i = 0; i < 4; i++) begin
      chk_fetch("ito/wait");
      tick();
    end
    #1;
    chk("ito/pulse", pk(0, 0, 0, 4'h0, 0, 0, cur_isel, 0, 0, 2'd0, 2'd0, 0, 1));
    tick();
    // Ack on the 4th request cycle, then ack on the cycle the counter hits the limit
    do_wb("ack_c4", I_ADD, 3, 4'b0000, 0, 0, 3'd0, 2'd0, 2'd0);
    do_wb("ack_c5", I_SUB, 4, 4'b0001, 0, 0, 3'd0, 2'd0, 2'd0);

    // Data timeout on a load
    fetch("lwto", I_LW, 0);
    decode("lwto", 3'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lwto/wait", pk(0, 1, 0, 4'h0, 0, 1, 3'd0, 0, 0, 2'd0, 2'd0, 0, 0));
      tick();
    end
    #1;
    chk("lwto/pulse", pk(0, 0, 0, 4'h0, 0, 1, 3'd0, 0, 0, 2'd0, 2'd0, 0, 1));
    tick();
    chk_fetch("lwto/refetch");

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    fetch("trap", I_ILL, 0);
    #1;
    chk_bit("trap/dec_illegal", illegal, 1'b0);
    decode("trap", 3'd0);
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      #1;
      chk("trap/hold", pk(0, 0, 0, 4'h0, 0, 0, 3'd0, 0, 0, 2'd0, 2'd0, 0, 0));
      chk_bit("trap/illegal", illegal, 1'b1);
      tick();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_bit("trap/reset_illegal", illegal, 1'b0);
    tick();
    rst_n = 1'b1;
    cur_isel = 3'd0;
    chk_fetch("trap/restart");
`else
    fetch("nop", I_ILL, 0);
    decode("nop", 3'd0);
    #1;
    chk("nop/exec", pk(0, 0, 0, 4'h0, 0, 0, 3'd0, 0, 0, 2'd0, 2'd0, 1, 0));
    tick();
    chk_fetch("nop/next");
`endif

    // Reset asserted mid-MEM drops the data request immediately
    fetch("rstmem", I_SW, 0);
    decode("rstmem", 3'd1);
    tick();
    #1;
    chk("rstmem/mem", pk(0, 1, 1, 4'h0, 0, 1, 3'd1, 0, 0, 2'd0, 2'd0, 0, 0));
    rst_n = 1'b0;
    #1;
    chk("rstmem/abort", '0);
    cur_isel = 3'd0;
    tick();
    tick();
    rst_n = 1'b1;
    do_wb("post_rst", I_ADD, 0, 4'b0000, 0, 0, 3'd0, 2'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
